// File: rtl/reg_arbiter.sv
// reg_arbiter: host/sequencer write arbitration into a shadow bank that is
// committed to the live pulse-channel registers on the 240 Hz frame tick.
module reg_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_240hz,
  input  logic       seq_enable,
  input  logic       host_valid,
  input  logic [1:0] host_addr,
  input  logic [7:0] host_data,
  output logic       host_ready,
  input  logic       seq_valid,
  input  logic [1:0] seq_addr,
  input  logic [7:0] seq_data,
  output logic       seq_ready,
  output logic [7:0] reg_4000,
  output logic [7:0] reg_4001,
  output logic [7:0] reg_4002,
  output logic [7:0] reg_4003,
  output logic       reg_change,
  output logic       restart
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic [3:0] dirty_q, dirty_d;
  logic [3:0][7:0] shadow_q, shadow_d, live_q, live_d;
  logic reg_change_q, reg_change_d, restart_q, restart_d;
  logic seq_elig, seq_grant, host_grant, wr, commit;
  logic [1:0] wa;
  logic [7:0] wd;
  always_comb begin
    seq_elig = seq_valid && seq_enable;
    seq_grant = seq_elig && (!host_valid || starve_cnt_q == LIMIT);
    host_grant = host_valid && !seq_grant;
    wr = seq_grant || host_grant;
    wa = seq_grant ? seq_addr : host_addr;
    wd = seq_grant ? seq_data : host_data;
    commit = enable_240hz && |dirty_q;
    starve_cnt_d = (seq_elig && !seq_grant) ? starve_cnt_q + 4'd1 : 4'd0;
    shadow_d = shadow_q;
    if (wr) shadow_d[wa] = wd;
    // the commit clears dirty first, so a write on the commit edge survives to the next tick
    dirty_d = (commit ? 4'd0 : dirty_q) | (wr ? 4'd1 << wa : 4'd0);
    for (int i = 0; i < 4; i++) live_d[i] = (commit && dirty_q[i]) ? shadow_q[i] : live_q[i];
    reg_change_d = commit;
    restart_d = commit && dirty_q[3];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      dirty_q <= '0;
      shadow_q <= '0;
      live_q <= '0;
      reg_change_q <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      dirty_q <= dirty_d;
      shadow_q <= shadow_d;
      live_q <= live_d;
      reg_change_q <= reg_change_d;
      restart_q <= restart_d;
    end
  end
  assign host_ready = host_grant;
  assign seq_ready = seq_grant;
  assign reg_4000 = live_q[0];
  assign reg_4001 = live_q[1];
  assign reg_4002 = live_q[2];
  assign reg_4003 = live_q[3];
  assign reg_change = reg_change_q;
  assign restart = restart_q;
endmodule

// File: tb/tb_reg_arbiter.sv
// tb_reg_arbiter: scoreboard bench for reg_arbiter; commit results and grant
// patterns are queued as stimulus is driven and popped when the DUT responds.
module tb_reg_arbiter;
  logic clk, rst, enable_240hz, seq_enable;
  logic host_valid, seq_valid, host_ready, seq_ready;
  logic [1:0] host_addr, seq_addr;
  logic [7:0] host_data, seq_data;
  logic [7:0] reg_4000, reg_4001, reg_4002, reg_4003;
  logic reg_change, restart;
  logic [31:0] live;
  typedef struct {
    logic [31:0] live;
    logic chg;
    logic rs;
  } exp_t;
  exp_t sb[$];
  logic [1:0] gq[$];
  logic [3:0][7:0] m_shadow, m_live;
  logic [3:0] m_dirty;
  int checks = 0;
  int errors = 0;

  reg_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .enable_240hz(enable_240hz), .seq_enable(seq_enable),
    .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data), .host_ready(host_ready),
    .seq_valid(seq_valid), .seq_addr(seq_addr), .seq_data(seq_data), .seq_ready(seq_ready),
    .reg_4000(reg_4000), .reg_4001(reg_4001), .reg_4002(reg_4002), .reg_4003(reg_4003),
    .reg_change(reg_change), .restart(restart)
  );

  assign live = {reg_4003, reg_4002, reg_4001, reg_4000};
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    host_valid = 1'b0;
    seq_valid = 1'b0;
    enable_240hz = 1'b0;
  endtask

  task automatic model_clear();
    m_shadow = '0;
    m_live = '0;
    m_dirty = '0;
    sb.delete();
    gq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    seq_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // one cycle: optional host write, optional frame tick; a tick pushes the expected commit
  task automatic cyc(input logic hv, input logic [1:0] a, input logic [7:0] d, input logic tk);
    exp_t e;
    @(negedge clk);
    host_valid = hv;
    host_addr = a;
    host_data = d;
    enable_240hz = tk;
    if (tk) begin
      e.chg = |m_dirty;
      e.rs = m_dirty[3];
      for (int i = 0; i < 4; i++) if (m_dirty[i]) m_live[i] = m_shadow[i];
      e.live = m_live;
      m_dirty = '0;
      sb.push_back(e);
    end
    if (hv) begin
      m_shadow[a] = d;
      m_dirty[a] = 1'b1;
    end
    #1;
    if (hv) begin
      checks++;
      if (host_ready !== 1'b1) begin
        errors++;
        $display("FAIL host_ready: got %b want 1", host_ready);
      end
    end
    @(posedge clk);
    #1;
    idle();
    if (tk) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: empty");
      end else begin
        e = sb.pop_front();
        checks++;
        if (live !== e.live) begin
          errors++;
          $display("FAIL live_regs: got %h want %h", live, e.live);
        end
        checks++;
        if ({reg_change, restart} !== {e.chg, e.rs}) begin
          errors++;
          $display("FAIL pulses: got chg=%b rs=%b want chg=%b rs=%b", reg_change, restart, e.chg, e.rs);
        end
      end
      @(posedge clk);
      #1;
      checks++;
      if ({reg_change, restart} !== 2'b00) begin
        errors++;
        $display("FAIL pulse_width: got chg=%b rs=%b want 0 0", reg_change, restart);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({live, reg_change, restart} !== 34'd0) begin
      errors++;
      $display("FAIL reset_state: got live=%h chg=%b rs=%b want 0", live, reg_change, restart);
    end
    cyc(1'b1, 2'd0, 8'h55, 1'b0);
    cyc(1'b0, 2'd0, 8'h00, 1'b1);
    cyc(1'b1, 2'd3, 8'hBB, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({live, reg_change, restart} !== 34'd0) begin
      errors++;
      $display("FAIL async_reset: got live=%h chg=%b rs=%b want 0", live, reg_change, restart);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    cyc(1'b0, 2'd0, 8'h00, 1'b1);
  endtask

  task automatic test_commit();
    do_reset();
    cyc(1'b1, 2'd2, 8'hFD, 1'b0);
    cyc(1'b1, 2'd3, 8'h08, 1'b0);
    checks++;
    if ({live, reg_change} !== 33'd0) begin
      errors++;
      $display("FAIL no_early_commit: got live=%h chg=%b want 0", live, reg_change);
    end
    cyc(1'b0, 2'd0, 8'h00, 1'b1);
  endtask

  task automatic test_last_write_wins();
    do_reset();
    cyc(1'b1, 2'd0, 8'h11, 1'b0);
    cyc(1'b1, 2'd0, 8'h22, 1'b0);
    cyc(1'b0, 2'd0, 8'h00, 1'b1);
  endtask

  task automatic test_starve();
    logic [1:0] g, prev;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) gq.push_back(2'b10);
      gq.push_back(2'b01);
    end
    @(negedge clk);
    seq_enable = 1'b1;
    host_valid = 1'b1;
    seq_valid = 1'b1;
    host_addr = 2'd0;
    host_data = 8'h01;
    seq_addr = 2'd1;
    seq_data = 8'h02;
    prev = 2'b00;
    for (int c = 0; c < 15; c++) begin
      #1;
      g = gq.pop_front();
      checks++;
      if ({host_ready, seq_ready} !== g) begin
        errors++;
        $display("FAIL grant[%0d]: got %b want %b", c, {host_ready, seq_ready}, g);
      end
      checks++;
      if (prev[0] && seq_ready) begin
        errors++;
        $display("FAIL seq_back_to_back[%0d]: got seq_ready=1 twice want not", c);
      end
      prev = {host_ready, seq_ready};
      @(negedge clk);
    end
    idle();
    seq_enable = 1'b0;
  endtask

  task automatic test_seq_disable();
    logic [1:0] g;
    do_reset();
    @(negedge clk);
    seq_valid = 1'b1;
    host_valid = 1'b1;
    host_addr = 2'd2;
    host_data = 8'h33;
    seq_addr = 2'd3;
    seq_data = 8'h44;
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if ({host_ready, seq_ready} !== 2'b10) begin
        errors++;
        $display("FAIL seq_locked[%0d]: got %b want 10", c, {host_ready, seq_ready});
      end
      @(negedge clk);
    end
    seq_enable = 1'b1;
    for (int k = 0; k < 4; k++) gq.push_back(2'b10);
    gq.push_back(2'b01);
    for (int c = 0; c < 5; c++) begin
      #1;
      g = gq.pop_front();
      checks++;
      if ({host_ready, seq_ready} !== g) begin
        errors++;
        $display("FAIL starve_after_lock[%0d]: got %b want %b", c, {host_ready, seq_ready}, g);
      end
      @(negedge clk);
    end
    host_valid = 1'b0;
    #1;
    checks++;
    if (seq_ready !== 1'b1) begin
      errors++;
      $display("FAIL seq_alone: got %b want 1", seq_ready);
    end
    @(negedge clk);
    idle();
    seq_enable = 1'b0;
  endtask

  task automatic test_same_edge_commit();
    do_reset();
    cyc(1'b1, 2'd1, 8'h7F, 1'b1);
    cyc(1'b0, 2'd0, 8'h00, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    seq_enable = 1'b0;
    host_addr = '0;
    host_data = '0;
    seq_addr = '0;
    seq_data = '0;
    model_clear();
    test_reset();
    test_commit();
    test_last_write_wins();
    test_starve();
    test_seq_disable();
    test_same_edge_commit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_arbiter.md
Name: reg_arbiter

Overview:
- Shares the pulse-channel register bank (4000-4003) between two writers: the serial host path (decoder) and an on-chip tune sequencer.
- Accepted writes land in a shadow bank. The shadow bank is copied to the live registers only on a 240 Hz frame tick, so the rectangle channel sees glitch-free, frame-aligned updates.
- Sits between decoder/sequencer and rectangle. It replaces the direct decoder-to-rectangle register connection.

Parameters:
- STARVE_LIMIT, 4, consecutive denied sequencer cycles before the sequencer is forced a grant (legal range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- enable_240hz  in  1  one-cycle frame tick from frame
- seq_enable  in  1  0 = sequencer locked out
- host_valid  in  1  host write request
- host_addr  in  2  register index 0..3 (maps to 4000..4003)
- host_data  in  8  write data
- host_ready  out  1  host write accepted this cycle
- seq_valid  in  1  sequencer write request
- seq_addr  in  2  register index
- seq_data  in  8  write data
- seq_ready  out  1  sequencer write accepted this cycle
- reg_4000  out  8  live register 0
- reg_4001  out  8  live register 1
- reg_4002  out  8  live register 2
- reg_4003  out  8  live register 3
- reg_change  out  1  one-cycle pulse: live bank updated
- restart  out  1  one-cycle pulse with reg_change when reg 3 was part of the commit

Behaviour:
- Reset (async, any time): live regs, shadow regs, dirty[3:0], starve_cnt, reg_change and restart all go to 0. Pending shadow writes are discarded.
- Handshake:
  - valid/ready; ready is combinational from the current-cycle arbitration.
  - A write transfers at the rising edge where valid && ready.
  - The requester holds addr/data stable while valid && !ready.
  - At most one write is accepted per cycle.
- Arbitration:
  - seq_eligible = seq_valid && seq_enable.
  - host_valid only: host granted.
  - seq_eligible only: sequencer granted.
  - Both, starve_cnt < STARVE_LIMIT: host granted; starve_cnt increments.
  - Both, starve_cnt == STARVE_LIMIT: sequencer granted; starve_cnt clears.
  - starve_cnt clears whenever the sequencer is granted or seq_eligible == 0. It saturates at STARVE_LIMIT.
  - seq_enable == 0 forces seq_ready = 0 regardless of starve_cnt.
- Shadow write: on an accepted write, shadow[addr] <= data and dirty[addr] <= 1. A rewrite of the same address before a commit overwrites it: last write wins.
- Commit, at the edge where enable_240hz == 1 and dirty != 0:
  - live[i] <= shadow[i] for every i with dirty[i] set; clean registers are untouched.
  - dirty <= 0.
  - Next cycle: reg_change = 1; restart = 1 iff dirty[3] was set.
  - Both pulses last exactly one cycle.
- Tick with dirty == 0: no live update, no pulse.
- Write accepted on the same edge as a commit:
  - The commit uses the pre-write shadow and dirty.
  - The new write updates shadow and sets its dirty bit after the clear, so it commits on the next tick.
  - It is not lost.
- Latency: accepted write to visible live output = the next enable_240hz edge after acceptance, never the same edge.
- No combinational path from any *_valid to a live register output.

Test Plan:
1. Reset with rst=1 mid-sequence after writes are pending -> all reg_40xx = 0x00, reg_change = 0; after release and a tick, no pulse (dirty was cleared).
2. Host writes addr2 = 0xFD, then addr3 = 0x08, no tick between -> live regs unchanged. At the next tick, reg_4002 = 0xFD and reg_4003 = 0x08, and the cycle after, reg_change = 1 and restart = 1 for exactly one cycle.
3. Host writes addr0 = 0x11 then addr0 = 0x22 before a tick -> after the tick reg_4000 = 0x22, restart = 0.
4. host_valid and seq_valid held high continuously, seq_enable = 1, STARVE_LIMIT = 4 -> grant pattern host,host,host,host,seq repeating; seq_ready is never high two cycles in a row.
5. seq_enable = 0 with seq_valid high for 20 cycles -> seq_ready stays 0, starve_cnt stays 0. Raise seq_enable with no host request -> granted the same cycle.
6. Host write addr1 = 0x7F accepted on the same edge as enable_240hz, shadow otherwise clean -> no reg_change that frame. reg_4001 = 0x7F after the following tick, with a reg_change pulse.
